// File: rtl/mem_defs.sv
// Shared definitions for the M-stage memory controller: state encoding, widths, bus command payload.
package mem_defs;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } memStateT;

  // Latched bus command, held stable while a transaction is outstanding
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } busCmdT;

  // Word-aligned bus address from a byte address
  function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] byteAddr);
    return {byteAddr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Bus wait counter: clear has priority over enable; termCount flags TIMEOUT-1 reached.
module wait_counter
  import mem_defs::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic termCount
);

  logic [CNT_W-1:0] count;

  // Count BUSY cycles spent waiting for an ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal count compare
  assign termCount = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage load/store controller: issues one bus transaction per lw/sw, stalls the pipeline
// until ack or timeout, and flags misaligned, ambiguous or timed-out accesses.
module mem_stage_ctrl
  import mem_defs::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  output logic              errM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  memStateT          state;
  memStateT          stateNext;
  busCmdT            cmdQ;
  busCmdT            cmdD;
  logic              busReqD;
  logic [DATA_W-1:0] readdataD;
  logic              errD;
  logic              stallC;
  logic              cntClear;
  logic              cntEnable;
  logic              cntTerm;
  logic              accessReq;
  logic              aligned;

  assign accessReq = memreadM | memwriteM;
  assign aligned   = (aluoutM[1:0] == 2'b00);

  // Wait counter for the BUSY timeout
  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) uWaitCounter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cntClear),
    .enable    (cntEnable),
    .termCount (cntTerm)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, stall and next values of the registered outputs
  always_comb begin
    stateNext = state;
    cmdD      = cmdQ;
    busReqD   = bus_req;
    readdataD = readdataM;
    errD      = 1'b0;
    stallC    = 1'b0;
    cntClear  = 1'b0;
    cntEnable = 1'b0;
    unique case (state)
      IDLE: begin
        if (accessReq) begin
          if (aligned) begin
            // Both strobes high is resolved as a store and flagged
            stallC     = 1'b1;
            stateNext  = BUSY;
            busReqD    = 1'b1;
            cmdD.we    = memwriteM;
            cmdD.addr  = wordAddr(aluoutM);
            cmdD.wdata = writedataM;
            cntClear   = 1'b1;
            errD       = memreadM & memwriteM;
          end else begin
            errD = 1'b1;
            if (!memwriteM) begin
              readdataD = '0;
            end
          end
        end
      end
      BUSY: begin
        stallC = 1'b1;
        if (bus_ack) begin
          busReqD   = 1'b0;
          stateNext = DONE;
          if (!cmdQ.we) begin
            readdataD = bus_rdata;
          end
        end else if (cntTerm) begin
          busReqD   = 1'b0;
          stateNext = DONE;
          errD      = 1'b1;
          if (!cmdQ.we) begin
            readdataD = '0;
          end
        end else begin
          cntEnable = 1'b1;
        end
      end
      DONE: begin
        // Pipeline advances this cycle; never reissue the same instruction
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Registered bus command and M-stage results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmdQ      <= '0;
      bus_req   <= 1'b0;
      readdataM <= '0;
      errM      <= 1'b0;
    end else begin
      cmdQ      <= cmdD;
      bus_req   <= busReqD;
      readdataM <= readdataD;
      errM      <= errD;
    end
  end

  assign bus_we    = cmdQ.we;
  assign bus_addr  = cmdQ.addr;
  assign bus_wdata = cmdQ.wdata;

  // Stall is combinational so the issuing cycle already freezes the pipeline
  assign stallM = stallC & ~rst;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed + randomized bench for mem_stage_ctrl with a transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int unsigned MAIN_T = 12;
  localparam int unsigned ALT_T  = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        memreadM;
  logic        memwriteM;
  logic        bus_ack;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] bus_rdata;

  logic        mr0, mw0, ack0, mr4, mw4, ack4;
  logic [31:0] rd0, rd4, addr0, addr4, wd0, wd4;
  logic        stall0, stall4, err0, err4, req0, req4, we0, we4;

  logic [31:0] oRd, oAddr, oWd;
  logic        oStall, oErr, oReq, oWe;

  int          checks;
  int          errors;
  logic [31:0] expRd [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the selected instance sees requests and acks
  assign mr0  = memreadM  & ~sel;
  assign mw0  = memwriteM & ~sel;
  assign ack0 = bus_ack   & ~sel;
  assign mr4  = memreadM  & sel;
  assign mw4  = memwriteM & sel;
  assign ack4 = bus_ack   & sel;

  assign oRd    = sel ? rd4    : rd0;
  assign oAddr  = sel ? addr4  : addr0;
  assign oWd    = sel ? wd4    : wd0;
  assign oStall = sel ? stall4 : stall0;
  assign oErr   = sel ? err4   : err0;
  assign oReq   = sel ? req4   : req0;
  assign oWe    = sel ? we4    : we0;

  mem_stage_ctrl #(.TIMEOUT(MAIN_T)) dut (
    .clk        (clk),
    .rst        (rst),
    .memreadM   (mr0),
    .memwriteM  (mw0),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (rd0),
    .stallM     (stall0),
    .errM       (err0),
    .bus_req    (req0),
    .bus_we     (we0),
    .bus_addr   (addr0),
    .bus_wdata  (wd0),
    .bus_ack    (ack0),
    .bus_rdata  (bus_rdata)
  );

  mem_stage_ctrl #(.TIMEOUT(ALT_T)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .memreadM   (mr4),
    .memwriteM  (mw4),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (rd4),
    .stallM     (stall4),
    .errM       (err4),
    .bus_req    (req4),
    .bus_we     (we4),
    .bus_addr   (addr4),
    .bus_wdata  (wd4),
    .bus_ack    (ack4),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle with no memory instruction; an ack here must be ignored
  task automatic idleCycle(input logic ack);
    @(negedge clk);
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    bus_ack   = ack;
    bus_rdata = $urandom;
    #1;
    chk("idle_stall", 32'(oStall), 32'(0));
    chk("idle_req", 32'(oReq), 32'(0));
    chk("idle_err", 32'(oErr), 32'(0));
    chk("idle_rdata", oRd, expRd[sel]);
    bus_ack = 1'b0;
  endtask

  // One lw/sw instruction; ackAt = BUSY cycle carrying the ack (0 = never)
  task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ackAt, input logic [31:0] rdata);
    int   tmax;
    bit   misal;
    bit   acked;
    int   expBusy;
    int   busy;
    int   errSeen;
    bit   done;
    tmax    = sel ? int'(ALT_T) : int'(MAIN_T);
    misal   = (addr % 4) != 0;
    acked   = (ackAt != 0) && (ackAt <= tmax);
    expBusy = acked ? ackAt : tmax;
    busy    = 0;
    errSeen = 0;
    done    = 1'b0;

    @(negedge clk);
    memreadM   = rd;
    memwriteM  = wr;
    aluoutM    = addr;
    writedataM = wdata;
    bus_ack    = 1'b0;
    bus_rdata  = $urandom;
    #1;
    chk("issue_stall", 32'(oStall), 32'(!misal));
    chk("issue_req", 32'(oReq), 32'(0));
    chk("issue_err", 32'(oErr), 32'(0));

    if (misal) begin
      @(negedge clk);
      memreadM  = 1'b0;
      memwriteM = 1'b0;
      #1;
      if (!wr) expRd[sel] = 32'h0;
      chk("misal_err", 32'(oErr), 32'(1));
      chk("misal_req", 32'(oReq), 32'(0));
      chk("misal_stall", 32'(oStall), 32'(0));
      chk("misal_rdata", oRd, expRd[sel]);
      return;
    end

    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      bus_ack   = (i == ackAt);
      bus_rdata = bus_ack ? rdata : $urandom;
      #1;
      if (oErr) errSeen++;
      if (!oStall) begin
        done = 1'b1;
        break;
      end
      busy++;
      chk("busy_req", 32'(oReq), 32'(1));
      chk("busy_addr", oAddr, addr & 32'hFFFF_FFFC);
      chk("busy_we", 32'(oWe), 32'(wr));
      chk("busy_wdata", oWd, wdata);
    end
    bus_ack = 1'b0;

    if (!wr) expRd[sel] = acked ? rdata : 32'h0;
    chk("done_seen", 32'(done), 32'(1));
    chk("stall_cycles", 32'(busy + 1), 32'(expBusy + 1));
    chk("err_pulses", 32'(errSeen), 32'(int'(rd & wr) + int'(!acked)));
    chk("done_req", 32'(oReq), 32'(0));
    chk("done_rdata", oRd, expRd[sel]);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    checks     = 0;
    errors     = 0;
    expRd[0]   = 32'h0;
    expRd[1]   = 32'h0;
    sel        = 1'b0;
    rst        = 1'b1;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    bus_ack    = 1'b0;
    aluoutM    = 32'h0;
    writedataM = 32'h0;
    bus_rdata  = 32'h0;

    // Reset state
    #12;
    chk("rst_req", 32'(oReq), 32'(0));
    chk("rst_we", 32'(oWe), 32'(0));
    chk("rst_addr", oAddr, 32'h0);
    chk("rst_wdata", oWd, 32'h0);
    chk("rst_rdata", oRd, 32'h0);
    chk("rst_err", 32'(oErr), 32'(0));
    chk("rst_stall", 32'(oStall), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    idleCycle(1'b1);
    idleCycle(1'b0);

    // lw with ack in the first BUSY cycle
    doAccess(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
    idleCycle(1'b0);
    // sw acked in the fifth BUSY cycle
    doAccess(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 5, 32'hCAFE_0001);
    idleCycle(1'b0);
    // misaligned lw
    doAccess(1'b1, 1'b0, 32'h0000_0002, 32'h0, 1, 32'h1111_1111);
    idleCycle(1'b0);
    // back-to-back lw/sw/lw
    doAccess(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hA5A5_5A5A);
    doAccess(1'b0, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 1, 32'h0);
    doAccess(1'b1, 1'b0, 32'h0000_0108, 32'h0, 3, 32'h7777_8888);
    idleCycle(1'b0);
    // both strobes high: store plus error pulse
    doAccess(1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 2, 32'h9999_9999);
    idleCycle(1'b0);
    // ack on the very last cycle before timeout still completes
    doAccess(1'b1, 1'b0, 32'h0000_0044, 32'h0, int'(MAIN_T), 32'h1357_9BDF);
    idleCycle(1'b0);

    // TIMEOUT=4 instance: good read, then timeout and a late ack
    sel = 1'b1;
    doAccess(1'b1, 1'b0, 32'h0000_0080, 32'h0, 3, 32'hFEED_FACE);
    doAccess(1'b1, 1'b0, 32'h0000_0084, 32'h0, 0, 32'h0);
    idleCycle(1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    sel = 1'b0;

    // Reset in the third BUSY cycle
    @(negedge clk);
    memreadM = 1'b1;
    aluoutM  = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("pre_rst_req", 32'(oReq), 32'(1));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_req", 32'(oReq), 32'(0));
    chk("async_we", 32'(oWe), 32'(0));
    chk("async_addr", oAddr, 32'h0);
    chk("async_wdata", oWd, 32'h0);
    chk("async_rdata", oRd, 32'h0);
    chk("async_err", 32'(oErr), 32'(0));
    chk("async_stall", 32'(oStall), 32'(0));
    expRd[0] = 32'h0;
    expRd[1] = 32'h0;
    @(negedge clk);
    memreadM = 1'b0;
    rst      = 1'b0;
    idleCycle(1'b1);
    idleCycle(1'b0);
    doAccess(1'b1, 1'b0, 32'h0000_0204, 32'h0, 2, 32'h2468_ACE0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idleCycle(1'($urandom_range(0, 1)));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      kind = $urandom_range(0, 9);
      doAccess(kind <= 4 || kind == 9, kind >= 5, a, $urandom,
               int'($urandom_range(0, MAIN_T + 3)), $urandom);
    end
    idleCycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum cycles in BUSY waiting for bus_ack (legal range 2..255).
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-high.
REQ-004 Port: memreadM  in  1  M-stage load request (lw).
REQ-005 Port: memwriteM  in  1  M-stage store request (sw).
REQ-006 Port: aluoutM  in  32  byte address of the access.
REQ-007 Port: writedataM  in  32  store data.
REQ-008 Port: readdataM  out  32  load data presented to the writeback pipeline register.
REQ-009 Port: stallM  out  1  freeze the F/D/E/M pipeline registers while high.
REQ-010 Port: errM  out  1  one-cycle pulse on a misaligned access, an illegal access or a timeout.
REQ-011 Port: bus_req  out  1  bus request, registered.
REQ-012 Port: bus_we  out  1  1 = write, 0 = read; valid while bus_req is high.
REQ-013 Port: bus_addr  out  32  word address {aluoutM[31:2],2'b00}; valid while bus_req is high.
REQ-014 Port: bus_wdata  out  32  store data; valid while bus_req is high.
REQ-015 Port: bus_ack  in  1  single-cycle completion strobe from memory.
REQ-016 Port: bus_rdata  in  32  read data; valid only when bus_ack is high.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-018 In IDLE, when memreadM or memwriteM is high and aluoutM[1:0]==0, the block SHALL drive stallM high combinationally in that same cycle and move to BUSY.
REQ-019 On the IDLE->BUSY edge the block SHALL register bus_req=1 and latch bus_we, bus_addr and bus_wdata.
REQ-020 bus_addr, bus_we and bus_wdata SHALL remain stable until the ack is received.
REQ-021 In BUSY, stallM SHALL be 1 and bus_req SHALL be 1.
REQ-022 In BUSY, bus_ack=1 SHALL cause: bus_req cleared on the next edge, bus_rdata captured into readdataM (reads only), and a move to DONE.
REQ-023 In DONE, stallM SHALL be 0 for exactly one cycle; the next state SHALL be IDLE unconditionally, so the same instruction is never reissued.
REQ-024 readdataM SHALL hold its last captured value until the next captured read or timeout.
REQ-025 A write SHALL leave readdataM unchanged.
REQ-026 Latency: with bus_ack in the first BUSY cycle, the total stall SHALL be 2 cycles; in general the stall SHALL be (ack cycle index + 1).
REQ-027 A wait counter SHALL be 8 bits wide, cleared on entry to BUSY and incremented each BUSY cycle without ack.
REQ-028 When the counter reaches TIMEOUT-1 with no ack, the block SHALL drop bus_req, set readdataM to 0 for reads, pulse errM and move to DONE.
REQ-029 bus_ack while not in BUSY (for example, a late ack after a timeout) SHALL be ignored.
REQ-030 A misaligned access (aluoutM[1:0]!=0 with memreadM or memwriteM high) in IDLE SHALL issue no bus request, pulse errM and leave stallM at 0.
REQ-031 A misaligned read SHALL also load readdataM with 0.
REQ-032 memreadM and memwriteM both high SHALL be treated as a write and SHALL pulse errM.
REQ-033 With neither memreadM nor memwriteM high, the block SHALL stay in IDLE with stallM=0 and bus_req=0.

Reset
REQ-034 rst high SHALL immediately force: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, readdataM=0, counter=0, errM=0 and stallM=0.
REQ-035 Reset during BUSY SHALL abandon the transaction without completing it, and any subsequent ack SHALL be ignored per REQ-029.

Structure
REQ-036 The state encoding (2 bits) and the default TIMEOUT value SHALL live in a shared package/header, mem_defs.
REQ-037 The wait counter SHALL be a sub-module, wait_counter (clear, enable, terminal-count output).
REQ-038 All other logic SHALL reside in mem_stage_ctrl.

Verification
REQ-039 Scenario: lw with aluoutM=0x0000_0010 and bus_ack+bus_rdata=0xDEAD_BEEF in the first BUSY cycle -> bus_addr=0x10, bus_we=0, stallM high for 2 cycles, readdataM=0xDEADBEEF in DONE.
REQ-040 Scenario: sw with aluoutM=0x24, writedataM=0x1234_5678 and ack after 5 BUSY cycles -> bus_we=1, bus_wdata stable throughout, stallM high for 6 cycles, readdataM unchanged.
REQ-041 Scenario: lw with aluoutM=0x0000_0002 -> no bus_req, one errM pulse, readdataM=0, stallM=0.
REQ-042 Scenario: lw with TIMEOUT=4 and no ack -> bus_req drops after 4 BUSY cycles, one errM pulse, readdataM=0; a late ack 2 cycles later is ignored.
REQ-043 Scenario: rst asserted in the 3rd BUSY cycle -> all outputs 0 asynchronously; after release the block is in IDLE and the next lw completes normally.
REQ-044 Scenario: back-to-back lw/sw on consecutive instructions -> each is issued exactly once, with one DONE cycle between transactions.
